// File: rtl/porta_rolante_ctrl_pkg.sv
// porta_pkg: shared types and constants for the rolling-door controller.
// State encodings are fixed because estado drives the LED/debug display.
package porta_pkg;

    typedef enum logic [2:0] {
        INIT     = 3'd0,
        FECHADO  = 3'd1,
        ABRINDO  = 3'd2,
        ABERTO   = 3'd3,
        FECHANDO = 3'd4,
        PARADO   = 3'd5,
        FALHA    = 3'd6
    } estado_t;

    localparam int unsigned TRAVEL_MAX_DEF  = 100;
    localparam int unsigned HOLD_CYCLES_DEF = 50;

    // Board switch indices
    localparam int unsigned SWI_FECHAR = 0;
    localparam int unsigned SWI_ABRIR  = 1;
    localparam int unsigned SWI_BAIXO  = 2;
    localparam int unsigned SWI_CIMA   = 4;
    localparam int unsigned SWI_RESET  = 7;

    // Board LED indices
    localparam int unsigned LED_MOTOR_ABRINDO  = 0;
    localparam int unsigned LED_MOTOR_FECHANDO = 1;
    localparam int unsigned LED_ALARME         = 3;
    localparam int unsigned LED_CLK            = 7;

    // Width of the shared timer: must hold the larger of the two limits.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

    // States in which a motor runs and the travel watchdog is armed.
    function automatic logic is_travel_state(input estado_t s);
        return (s == INIT) || (s == ABRINDO) || (s == FECHANDO);
    endfunction

endpackage

// File: rtl/porta_rolante_ctrl_timer.sv
// porta_timer: clear/enable counter that saturates at all-ones.
// Clear has priority over enable; reset is synchronous, active-high.
module porta_timer #(
    parameter int unsigned CNT_W = 7
) (
    input  logic             clk_2,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;

    // Count register: clear, or advance while enabled and not saturated.
    always_ff @(posedge clk_2) begin
        if (reset || clr_i) begin
            count_q <= '0;
        end else if (en_i && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/porta_rolante_ctrl.sv
// porta_rolante_ctrl: rolling-door sequencing controller.
// Optional feature: define AUTO_CLOSE_EN to close automatically after
// HOLD_CYCLES in ABERTO (held off while obstaculo is high).
module porta_rolante_ctrl
    import porta_pkg::*;
#(
    parameter int unsigned TRAVEL_MAX  = TRAVEL_MAX_DEF,
    parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF
) (
    input  logic       clk_2,
    input  logic       reset,
    input  logic       cmd_abrir,
    input  logic       cmd_fechar,
    input  logic       em_baixo,
    input  logic       em_cima,
    input  logic       obstaculo,
    output logic       motor_abrindo,
    output logic       motor_fechando,
    output logic       alarme,
    output logic [2:0] estado,
    output logic       busy
);

    localparam int unsigned CNT_W = cnt_width(TRAVEL_MAX, HOLD_CYCLES);
    localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_MAX - 1);
`ifdef AUTO_CLOSE_EN
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
`endif

    estado_t          state_q, state_d;
    logic             motor_abrindo_q, motor_fechando_q, alarme_q, busy_q;
    logic             timer_clr, timer_en;
    logic [CNT_W-1:0] count;

    porta_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk_2   (clk_2),
        .reset   (reset),
        .clr_i   (timer_clr),
        .en_i    (timer_en),
        .count_o (count)
    );

    // Next-state selection, highest-priority condition first.
    always_comb begin
        state_d = state_q;
        if ((state_q != FALHA) && em_baixo && em_cima) begin
            state_d = FALHA;
        end else if (is_travel_state(state_q) && (count == TRAVEL_LAST)) begin
            state_d = FALHA;
        end else begin
            case (state_q)
                INIT: begin
                    if (em_baixo) state_d = FECHADO;
                end
                FECHADO: begin
                    if (cmd_abrir) state_d = ABRINDO;
                end
                ABRINDO: begin
                    if (em_cima)                      state_d = ABERTO;
                    else if (cmd_fechar && !cmd_abrir) state_d = PARADO;
                end
                ABERTO: begin
                    if (cmd_fechar && !cmd_abrir && !obstaculo) state_d = FECHANDO;
`ifdef AUTO_CLOSE_EN
                    else if ((count == HOLD_LAST) && !obstaculo) state_d = FECHANDO;
`endif
                end
                FECHANDO: begin
                    if (obstaculo || cmd_abrir) state_d = ABRINDO;
                    else if (em_baixo)          state_d = FECHADO;
                end
                PARADO: begin
                    if (cmd_abrir)                     state_d = ABRINDO;
                    else if (cmd_fechar && !obstaculo) state_d = FECHANDO;
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Timer runs in travel states (and in ABERTO for auto-close, stopping
    // at HOLD_CYCLES-1 so an obstacle simply holds the pending close).
    always_comb begin
        timer_clr = (state_d != state_q);
        timer_en  = 1'b0;
        case (state_q)
            INIT, ABRINDO, FECHANDO: timer_en = 1'b1;
`ifdef AUTO_CLOSE_EN
            ABERTO:                  timer_en = (count != HOLD_LAST);
`endif
            default:                 timer_en = 1'b0;
        endcase
    end

    // State register with outputs decoded from the next state, so every
    // output comes straight from a flop.
    always_ff @(posedge clk_2) begin
        if (reset) begin
            state_q          <= INIT;
            motor_abrindo_q  <= 1'b0;
            motor_fechando_q <= 1'b1;
            alarme_q         <= 1'b0;
            busy_q           <= 1'b1;
        end else begin
            state_q          <= state_d;
            motor_abrindo_q  <= (state_d == ABRINDO);
            motor_fechando_q <= (state_d == INIT) || (state_d == FECHANDO);
            alarme_q         <= (state_d == FALHA);
            busy_q           <= (state_d == ABRINDO) || (state_d == INIT) ||
                                (state_d == FECHANDO);
        end
    end

    assign motor_abrindo  = motor_abrindo_q;
    assign motor_fechando = motor_fechando_q;
    assign alarme         = alarme_q;
    assign busy           = busy_q;
    assign estado         = state_q;

endmodule

// File: tb/tb_porta_rolante_ctrl.sv
// Testbench for porta_rolante_ctrl (TRAVEL_MAX=8, HOLD_CYCLES=4).
// Table of directed vectors, hand sequences for auto-close, then random
// stimulus compared against a cycle-age reference model.
module tb_porta_rolante_ctrl;

    localparam int TM   = 8;
    localparam int HOLD = 4;

    logic       clk_2 = 1'b0;
    logic       reset, cmd_abrir, cmd_fechar, em_baixo, em_cima, obstaculo;
    logic       motor_abrindo, motor_fechando, alarme, busy;
    logic [2:0] estado;

    int total = 0;
    int bad   = 0;

    // Reference model: current state number and number of edges already
    // spent in it since entry.
    int m_st  = 0;
    int m_age = 0;

    porta_rolante_ctrl #(
        .TRAVEL_MAX  (TM),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk_2          (clk_2),
        .reset          (reset),
        .cmd_abrir      (cmd_abrir),
        .cmd_fechar     (cmd_fechar),
        .em_baixo       (em_baixo),
        .em_cima        (em_cima),
        .obstaculo      (obstaculo),
        .motor_abrindo  (motor_abrindo),
        .motor_fechando (motor_fechando),
        .alarme         (alarme),
        .estado         (estado),
        .busy           (busy)
    );

    always #5 clk_2 = ~clk_2;

    typedef struct {
        logic       r, a, f, b, c, o;
        logic [2:0] est;
        logic       ma, mf, al;
    } vec_t;

    vec_t vt[35];

    function automatic vec_t mk(input logic r, a, f, b, c, o,
                                input logic [2:0] est, input logic ma, mf, al);
        vec_t v;
        v.r = r; v.a = a; v.f = f; v.b = b; v.c = c; v.o = o;
        v.est = est; v.ma = ma; v.mf = mf; v.al = al;
        return v;
    endfunction

    // Output pattern the door display should show for a given state.
    function automatic logic [6:0] pattern_of(input int st);
        logic ma, mf, al;
        ma = (st == 2);
        mf = (st == 0) || (st == 4);
        al = (st == 6);
        return {3'(st), ma, mf, al, ma | mf};
    endfunction

    function automatic logic [6:0] dut_vec();
        return {estado, motor_abrindo, motor_fechando, alarme, busy};
    endfunction

    task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got {est,ma,mf,al,busy}=%b_%b required %b_%b",
                     name, $time, act[6:4], act[3:0], exp[6:4], exp[3:0]);
        end
    endtask

    // Reference step written directly from the door's rules.
    task automatic model_step(input logic r, a, f, b, c, o);
        int nx;
        bit travelling;
        nx = m_st;
        travelling = (m_st == 0) || (m_st == 2) || (m_st == 4);
        if (r) nx = 0;
        else if (m_st != 6 && b && c) nx = 6;
        else if (travelling && (m_age + 1 >= TM)) nx = 6;
        else begin
            case (m_st)
                0: if (b) nx = 1;
                1: if (a) nx = 2;
                2: if (c) nx = 3; else if (f && !a) nx = 4 + 1;
                3: begin
                    if (f && !a && !o) nx = 4;
`ifdef AUTO_CLOSE_EN
                    else if (m_age + 1 >= HOLD && !o) nx = 4;
`endif
                end
                4: if (o || a) nx = 2; else if (b) nx = 1;
                5: if (a) nx = 2; else if (f && !o) nx = 4;
                default: nx = m_st;
            endcase
        end
        if (r || nx != m_st) m_age = 0;
        else m_age++;
        m_st = nx;
    endtask

    task automatic apply(input logic r, a, f, b, c, o);
        reset = r; cmd_abrir = a; cmd_fechar = f;
        em_baixo = b; em_cima = c; obstaculo = o;
        @(posedge clk_2);
        #1;
        model_step(r, a, f, b, c, o);
        chk("model", dut_vec(), pattern_of(m_st));
    endtask

    initial begin
        reset = 1'b1; cmd_abrir = 1'b0; cmd_fechar = 1'b0;
        em_baixo = 1'b0; em_cima = 1'b0; obstaculo = 1'b0;

        //            r  a  f  b  c  o  est ma mf al
        vt[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        vt[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        vt[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        vt[3]  = mk(0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
        vt[4]  = mk(0, 1, 0, 1, 0, 0, 2, 1, 0, 0);
        for (int i = 5; i <= 8; i++) vt[i] = mk(0, 0, 0, 0, 0, 0, 2, 1, 0, 0);
        vt[9]  = mk(0, 0, 0, 0, 1, 0, 3, 0, 0, 0);
        vt[10] = mk(0, 0, 1, 0, 1, 0, 4, 0, 1, 0);
        vt[11] = mk(0, 0, 0, 0, 0, 0, 4, 0, 1, 0);
        vt[12] = mk(0, 0, 0, 0, 0, 1, 2, 1, 0, 0);
        for (int i = 13; i <= 19; i++) vt[i] = mk(0, 0, 0, 0, 0, 0, 2, 1, 0, 0);
        vt[20] = mk(0, 0, 0, 0, 0, 0, 6, 0, 0, 1);
        vt[21] = mk(0, 1, 0, 0, 0, 0, 6, 0, 0, 1);
        vt[22] = mk(0, 0, 0, 0, 0, 0, 6, 0, 0, 1);
        vt[23] = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        vt[24] = mk(0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
        vt[25] = mk(0, 0, 0, 1, 1, 0, 6, 0, 0, 1);
        vt[26] = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        vt[27] = mk(0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
        vt[28] = mk(0, 1, 0, 1, 0, 0, 2, 1, 0, 0);
        vt[29] = mk(0, 0, 1, 0, 0, 0, 5, 0, 0, 0);
        vt[30] = mk(0, 1, 1, 0, 0, 0, 2, 1, 0, 0);
        vt[31] = mk(0, 0, 1, 0, 0, 0, 5, 0, 0, 0);
        vt[32] = mk(0, 0, 1, 0, 0, 1, 5, 0, 0, 0);
        vt[33] = mk(0, 0, 1, 0, 0, 0, 4, 0, 1, 0);
        vt[34] = mk(0, 0, 0, 1, 0, 0, 1, 0, 0, 0);

        #2;
        foreach (vt[i]) begin
            apply(vt[i].r, vt[i].a, vt[i].f, vt[i].b, vt[i].c, vt[i].o);
            chk($sformatf("vec%0d", i), dut_vec(),
                {vt[i].est, vt[i].ma, vt[i].mf, vt[i].al, vt[i].ma | vt[i].mf});
        end

        // Hold in ABERTO with no commands (door is closed, FECHADO here).
        apply(0, 1, 0, 1, 0, 0);
        chk("hold_open", dut_vec(), pattern_of(2));
        apply(0, 0, 0, 0, 1, 0);
        chk("hold_aberto", dut_vec(), pattern_of(3));
        for (int i = 0; i < HOLD - 1; i++) begin
            apply(0, 0, 0, 0, 0, 0);
            chk("hold_wait", dut_vec(), pattern_of(3));
        end
        apply(0, 0, 0, 0, 0, 0);
`ifdef AUTO_CLOSE_EN
        chk("auto_close", dut_vec(), pattern_of(4));
        apply(0, 0, 0, 1, 0, 0);
        chk("auto_closed", dut_vec(), pattern_of(1));
        apply(0, 1, 0, 1, 0, 0);
        apply(0, 0, 0, 0, 1, 0);
        chk("auto_obst_aberto", dut_vec(), pattern_of(3));
        for (int i = 0; i < 6; i++) begin
            apply(0, 0, 0, 0, 0, 1);
            chk("auto_obst_hold", dut_vec(), pattern_of(3));
        end
        apply(0, 0, 0, 0, 0, 0);
        chk("auto_obst_release", dut_vec(), pattern_of(4));
`else
        chk("no_auto", dut_vec(), pattern_of(3));
        for (int i = 0; i < 20; i++) begin
            apply(0, 0, 0, 0, 0, 0);
            chk("no_auto_hold", dut_vec(), pattern_of(3));
        end
`endif

        // Randomized stimulus against the reference model.
        apply(1, 0, 0, 0, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            apply($urandom_range(0, 29) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 5) == 0,
                  $urandom_range(0, 5) == 0,
                  $urandom_range(0, 4) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
